// File: rtl/rrat.sv
// Retirement RAT: committed arch->phys map plus committed free-register bitmap.
// Each accepted commit remaps rd and releases rd's previous physical register.
module rrat #(
    parameter int P_REG_SIZE = 128,
    parameter int P_WIDTH    = 7,
    parameter int A_REGS     = 32,
    parameter int A_WIDTH    = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        commit_valid,
    input  logic [A_WIDTH-1:0]          commit_rd,
    input  logic [P_WIDTH-1:0]          commit_pd,
    output logic                        fl_enque,
    output logic [P_WIDTH-1:0]          freed_reg_phys,
    output logic [P_REG_SIZE-1:0]       backup_free_list,
    output logic [A_REGS*P_WIDTH-1:0]   rrat_map,
    output logic [P_WIDTH:0]            free_count
);

    localparam logic [P_WIDTH:0] RESET_COUNT = (P_WIDTH+1)'(P_REG_SIZE - A_REGS);

    logic                  accept;
    logic                  degenerate;
    logic                  inc;
    logic                  dec;
    logic [P_WIDTH-1:0]    old_pd;
    logic [P_WIDTH:0]      count_next;

    logic [P_REG_SIZE-1:0] backup_reg;
    logic                  fl_enque_reg;
    logic [P_WIDTH-1:0]    freed_reg;
    logic [P_WIDTH:0]      count_reg;

    always_comb begin
        accept     = commit_valid && (commit_rd != '0);
        old_pd     = rrat_map[commit_rd*P_WIDTH +: P_WIDTH];
        degenerate = (old_pd == commit_pd);
        // Count tracks the bitmap incrementally: old becomes free, pd becomes busy.
        inc        = !degenerate && !backup_reg[old_pd];
        dec        = backup_reg[commit_pd];
        count_next = count_reg + {{P_WIDTH{1'b0}}, inc} - {{P_WIDTH{1'b0}}, dec};
    end

    // One register per architectural entry; entry 0 can never be written.
    for (genvar gi = 0; gi < A_REGS; gi++) begin : gen_map
        logic [P_WIDTH-1:0] entry_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                entry_reg <= P_WIDTH'(gi);
            end else if (accept && (commit_rd == A_WIDTH'(gi))) begin
                entry_reg <= commit_pd;
            end
        end

        assign rrat_map[gi*P_WIDTH +: P_WIDTH] = entry_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            backup_reg   <= {{(P_REG_SIZE-A_REGS){1'b1}}, {A_REGS{1'b0}}};
            fl_enque_reg <= 1'b0;
            freed_reg    <= '0;
            count_reg    <= RESET_COUNT;
        end else begin
            fl_enque_reg <= 1'b0;
            if (accept) begin
                if (!degenerate) begin
                    backup_reg[old_pd] <= 1'b1;
                    fl_enque_reg       <= 1'b1;
                    freed_reg          <= old_pd;
                end
                backup_reg[commit_pd] <= 1'b0;
                count_reg             <= count_next;
            end
        end
    end

    assign fl_enque         = fl_enque_reg;
    assign freed_reg_phys   = freed_reg;
    assign backup_free_list = backup_reg;
    assign free_count       = count_reg;

endmodule

// File: tb/tb_rrat.sv
// Scoreboard bench for rrat: stimulus pushes expected post-edge state, a
// negedge monitor pops and compares, and also checks map/bitmap invariants.
module tb_rrat;
    localparam int PR = 128;
    localparam int PW = 7;
    localparam int AR = 32;
    localparam int AW = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                commit_valid = 1'b0;
    logic [AW-1:0]       commit_rd = '0;
    logic [PW-1:0]       commit_pd = '0;
    logic                fl_enque;
    logic [PW-1:0]       freed_reg_phys;
    logic [PR-1:0]       backup_free_list;
    logic [AR*PW-1:0]    rrat_map;
    logic [PW:0]         free_count;

    rrat #(.P_REG_SIZE(PR), .P_WIDTH(PW), .A_REGS(AR), .A_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .commit_valid(commit_valid),
        .commit_rd(commit_rd),
        .commit_pd(commit_pd),
        .fl_enque(fl_enque),
        .freed_reg_phys(freed_reg_phys),
        .backup_free_list(backup_free_list),
        .rrat_map(rrat_map),
        .free_count(free_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              enq;
        logic [PW:0]       cnt;
        logic [PR-1:0]     bk;
        logic [AR*PW-1:0]  mp;
        string             tag;
    } exp_t;

    exp_t          state_q[$];
    logic [PW-1:0] freed_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    logic [PW-1:0] m_map[AR];
    logic [PR-1:0] m_bk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t snapshot(input logic enq, input string tag);
        exp_t e;
        e.enq = enq;
        e.cnt = (PW+1)'($countones(m_bk));
        e.bk  = m_bk;
        for (int a = 0; a < AR; a++) e.mp[a*PW +: PW] = m_map[a];
        e.tag = tag;
        return e;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < AR; a++) m_map[a] = PW'(a);
        m_bk = {{(PR-AR){1'b1}}, {AR{1'b0}}};
    endtask

    task automatic commit(input logic v, input logic [AW-1:0] rd, input logic [PW-1:0] pd,
                          input string tag, input bit verbose);
        logic          enq;
        logic [PW-1:0] old;
        commit_valid = v;
        commit_rd    = rd;
        commit_pd    = pd;
        enq = 1'b0;
        old = '0;
        if (v && rd != '0) begin
            old = m_map[rd];
            if (old != pd) begin
                enq = 1'b1;
                m_bk[old] = 1'b1;
            end
            m_bk[pd]  = 1'b0;
            m_map[rd] = pd;
        end
        @(posedge clk);
        state_q.push_back(snapshot(enq, tag));
        if (enq) freed_q.push_back(old);
        if (verbose)
            $display("commit %s: valid=%0d rd=%0d pd=%0d expect_enque=%0d expect_freed=%0d",
                     tag, v, rd, pd, enq, old);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        commit_valid = 1'b0;
        #1;
        state_q.delete();
        freed_q.delete();
        model_reset();
        state_q.push_back(snapshot(1'b0, "reset"));
        $display("reset asserted for %0d cycles", cycles);
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare expected state and every freed register the DUT reports.
    exp_t e_mon;
    int   used[PR];
    logic part_ok;
    always @(negedge clk) begin
        if (state_q.size() > 0) begin
            e_mon = state_q.pop_front();
            chk({e_mon.tag, " fl_enque"}, 256'(fl_enque), 256'(e_mon.enq));
            chk({e_mon.tag, " free_count"}, 256'(free_count), 256'(e_mon.cnt));
            chk({e_mon.tag, " backup"}, 256'(backup_free_list), 256'(e_mon.bk));
            chk({e_mon.tag, " rrat_map"}, 256'(rrat_map), 256'(e_mon.mp));
        end
        if (fl_enque) begin
            if (freed_q.size() == 0) begin
                chk("unexpected fl_enque", 256'(1), 256'(0));
            end else begin
                chk("freed_reg_phys", 256'(freed_reg_phys), 256'(freed_q.pop_front()));
            end
        end
        chk("popcount", 256'($countones(backup_free_list)), 256'(free_count));
        for (int p = 0; p < PR; p++) used[p] = 0;
        for (int a = 0; a < AR; a++) used[rrat_map[a*PW +: PW]]++;
        part_ok = (rrat_map[PW-1:0] == '0) && !backup_free_list[0];
        for (int p = 1; p < PR; p++)
            if (used[p] + int'(backup_free_list[p]) != 1) part_ok = 1'b0;
        chk("partition", 256'(part_ok), 256'(1));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] pd;
        logic [AW-1:0] rd;
        int            r;

        do_reset(3);
        commit(1'b0, 5'd0, 7'd0, "idle_after_reset", 1);

        commit(1'b1, 5'd5, 7'd40, "rd5_pd40", 1);
        commit(1'b0, 5'd0, 7'd0, "idle_pulse_end", 1);

        commit(1'b1, 5'd0, 7'd41, "rd0_pd41", 1);
        commit(1'b0, 5'd9, 7'd42, "invalid_rd9", 1);

        commit(1'b1, 5'd7, 7'd50, "rd7_pd50", 1);
        commit(1'b1, 5'd7, 7'd51, "rd7_pd51", 1);
        commit(1'b0, 5'd0, 7'd0, "idle_after_b2b", 1);

        commit(1'b1, 5'd3, 7'd3, "rd3_pd3_degenerate", 1);
        commit(1'b0, 5'd0, 7'd0, "idle_after_degenerate", 1);

        commit(1'b1, 5'd31, 7'd127, "rd31_pd127", 1);
        commit(1'b1, 5'd1, 7'd32, "rd1_pd32", 1);
        commit(1'b0, 5'd0, 7'd0, "idle_after_edges", 1);

        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) do_reset(2);
            r  = int'($urandom_range(0, 99));
            rd = AW'($urandom_range(0, AR-1));
            if (r < 5) begin
                commit(1'b0, rd, PW'($urandom_range(0, PR-1)), "rand_idle", 0);
            end else if (r < 10) begin
                commit(1'b1, rd, m_map[rd], "rand_degenerate", 0);
            end else begin
                do pd = PW'($urandom_range(1, PR-1)); while (!m_bk[pd]);
                commit(1'b1, rd, pd, "rand_commit", 0);
            end
        end

        commit(1'b0, 5'd0, 7'd0, "drain0", 0);
        commit(1'b0, 5'd0, 7'd0, "drain1", 0);
        @(negedge clk);
        #1;
        chk("queues_drained", 256'(state_q.size() + freed_q.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
